bit_stream_serializer: RTL and testbench



---
 rtl/seq_pkg.sv | 18 +
 rtl/ser_pending_buf.sv | 44 ++++
 rtl/bit_stream_serializer.sv | 115 +++++++++++
 tb/tb_bit_stream_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the bit-stream serializer: default sizes, FSM state
// encoding and the word-length legality check.
package seq_pkg;

  localparam int W_DEFAULT     = 11;
  localparam int LEN_W_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // A length is legal when it names at least one bit and no more than the word holds.
  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/ser_pending_buf.sv
// One-entry holding register (data + length) that parks a word while the
// shifter is still busy; its full flag is the back-pressure for the upstream.
module ser_pending_buf #(
  parameter int W     = 11,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             take,
  input  logic [W-1:0]     load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic [W-1:0]     data,
  output logic [LEN_W-1:0] len,
  output logic             full,
  output logic             ready
);

  logic             full_reg;
  logic [W-1:0]     data_reg;
  logic [LEN_W-1:0] len_reg;

  // Capture a parked word or release it to the shifter; load and take never coincide
  // because ready is low whenever the entry is occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
      len_reg  <= '0;
    end else if (load) begin
      full_reg <= 1'b1;
      data_reg <= load_data;
      len_reg  <= load_len;
    end else if (take) begin
      full_reg <= 1'b0;
    end
  end

  assign data  = data_reg;
  assign len   = len_reg;
  assign full  = full_reg;
  assign ready = !full_reg;

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter: words arrive over valid/ready and leave MSB-first,
// one bit per clock, with a one-word pending buffer for gap-free streaming.
module bit_stream_serializer
  import seq_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             len_err
);

  state_t           state_reg;
  logic [W-1:0]     shift_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic             frame_reg;
  logic             len_err_reg;

  logic             pend_full;
  logic             pend_ready;
  logic [W-1:0]     pend_data;
  logic [LEN_W-1:0] pend_len;

  logic             accept;
  logic             legal;
  logic             last_bit;
  logic             direct_load;
  logic             pend_load;
  logic             pend_take;

  // Left-align a word so its first bit to send sits in the shifter MSB.
  function automatic logic [W-1:0] align(input logic [W-1:0] d, input logic [LEN_W-1:0] len);
    return d << (W - int'(len));
  endfunction

  assign accept      = in_valid && in_ready;
  assign legal       = len_legal(int'(in_len), W);
  assign last_bit    = (state_reg == ST_SHIFT) && (cnt_reg == LEN_W'(1));
  assign direct_load = accept && legal && ((state_reg == ST_IDLE) || (last_bit && !pend_full));
  assign pend_load   = accept && legal && !direct_load;
  assign pend_take   = last_bit && pend_full;

  ser_pending_buf #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pend_load),
    .take      (pend_take),
    .load_data (in_data),
    .load_len  (in_len),
    .data      (pend_data),
    .len       (pend_len),
    .full      (pend_full),
    .ready     (pend_ready)
  );

  // Shifter FSM: load a new frame (parked word first), otherwise advance one bit
  // per clock and fall back to IDLE with an all-zero shifter after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      frame_reg <= 1'b0;
    end else if (pend_take) begin
      state_reg <= ST_SHIFT;
      shift_reg <= align(pend_data, pend_len);
      cnt_reg   <= pend_len;
      frame_reg <= 1'b1;
    end else if (direct_load) begin
      state_reg <= ST_SHIFT;
      shift_reg <= align(in_data, in_len);
      cnt_reg   <= in_len;
      frame_reg <= 1'b1;
    end else begin
      frame_reg <= 1'b0;
      if (state_reg == ST_SHIFT) begin
        if (last_bit) begin
          state_reg <= ST_IDLE;
          shift_reg <= '0;
          cnt_reg   <= '0;
        end else begin
          shift_reg <= {shift_reg[W-2:0], 1'b0};
          cnt_reg   <= cnt_reg - LEN_W'(1);
        end
      end
    end
  end

  // A bad length is swallowed and flagged for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_err_reg <= 1'b0;
    end else begin
      len_err_reg <= accept && !legal;
    end
  end

  assign in_ready    = pend_ready;
  assign dout        = shift_reg[W-1];
  assign dout_valid  = (state_reg == ST_SHIFT);
  assign frame_start = frame_reg;
  assign len_err     = len_err_reg;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: inputs driven and outputs sampled
// on the falling clock edge, expectations hand-computed from the word patterns.
module tb_bit_stream_serializer;

  localparam int W     = 11;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     in_data;
  logic [LEN_W-1:0] in_len;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             len_err;

  int total = 0;
  int bad   = 0;

  bit_stream_serializer #(.W(W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_len      (in_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_dout, input logic e_valid,
                         input logic e_fs, input logic e_ready);
    chk({tag, ".dout"}, 32'(dout), 32'(e_dout));
    chk({tag, ".valid"}, 32'(dout_valid), 32'(e_valid));
    chk({tag, ".fs"}, 32'(frame_start), 32'(e_fs));
    chk({tag, ".ready"}, 32'(in_ready), 32'(e_ready));
    $display("step %s: dout=%0b valid=%0b fs=%0b ready=%0b len_err=%0b",
             tag, dout, dout_valid, frame_start, in_ready, len_err);
  endtask

  task automatic offer(input logic [W-1:0] d, input logic [LEN_W-1:0] l);
    in_data  = d;
    in_len   = l;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [10:0] w11;
    logic [6:0]  b2b_bits;
    logic [6:0]  b2b_fs;
    logic [6:0]  b2b_rdy;
    logic [4:0]  dl_bits;
    logic [4:0]  dl_fs;

    rst_n    = 1'b0;
    in_data  = '0;
    in_len   = '0;
    in_valid = 1'b0;

    // Reset values before any clock edge
    #2;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset.len_err", 32'(len_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single 11-bit word, MSB first
    w11 = 11'b11011011101;
    offer(w11, 4'd11);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk_out($sformatf("single[%0d]", i), w11[10-i], 1'b1, (i == 0), 1'b1);
    end
    @(negedge clk);
    chk_out("single.end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back through the pending buffer: 1101 then 011
    b2b_bits = 7'b1101011;
    b2b_fs   = 7'b1000100;
    b2b_rdy  = 7'b1000111;
    offer(11'b1101, 4'd4);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk_out($sformatf("b2b[%0d]", i), b2b_bits[6-i], 1'b1, b2b_fs[6-i], b2b_rdy[6-i]);
      if (i == 0) offer(11'b011, 4'd3);
    end
    @(negedge clk);
    chk_out("b2b.end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Direct load while the last bit is on dout: 11 then 010, no gap
    dl_bits = 5'b11010;
    dl_fs   = 5'b10100;
    offer(11'b11, 4'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk_out($sformatf("direct[%0d]", i), dl_bits[4-i], 1'b1, dl_fs[4-i], 1'b1);
      if (i == 1) offer(11'b010, 4'd3);
    end
    @(negedge clk);
    chk_out("direct.end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Illegal lengths 0 and 12
    offer(11'h7FF, 4'd0);
    @(negedge clk);
    chk("len0.len_err", 32'(len_err), 32'd1);
    chk_out("len0", 1'b0, 1'b0, 1'b0, 1'b1);
    offer(11'h7FF, 4'd12);
    @(negedge clk);
    in_valid = 1'b0;
    chk("len12.len_err", 32'(len_err), 32'd1);
    chk_out("len12", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("len_err.clear", 32'(len_err), 32'd0);
    chk_out("illegal.end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during bit 5 of an 11-bit word
    w11 = 11'b11111111111;
    offer(w11, 4'd11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk_out($sformatf("abort[%0d]", i), 1'b1, 1'b1, (i == 0), 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk_out("abort.async", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out($sformatf("abort.after[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Length-1 word, three idle cycles, then 10
    offer(11'b1, 4'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("len1", 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out($sformatf("gap[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    offer(11'b10, 4'd2);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("len2[0]", 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk_out("len2[1]", 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk_out("len2.end", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
